// File: rtl/tt_sweep_pkg.sv
// Shared types and sizes for the truth-table sweeper.
package tt_sweep_pkg;

    localparam int unsigned TT_WIDTH = 8;
    localparam int unsigned IDX_W    = 3;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TT_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/result bus of the truth-table sweeper.
// Optional members o_fail_valid/o_first_fail exist when TT_SWEEP_FAIL_INFO_EN is defined.
interface truth_table_sweeper_if;
    import tt_sweep_pkg::*;

    logic                i_start;
    logic [TT_WIDTH-1:0] i_expected;
    logic                o_busy;
    logic                o_done;
    logic [TT_WIDTH-1:0] o_table;
    logic                o_match;
`ifdef TT_SWEEP_FAIL_INFO_EN
    logic                o_fail_valid;
    logic [IDX_W-1:0]    o_first_fail;
`endif

    modport master (
        output i_start,
        output i_expected,
        input  o_busy,
        input  o_done,
        input  o_table,
        input  o_match
`ifdef TT_SWEEP_FAIL_INFO_EN
        ,
        input  o_fail_valid,
        input  o_first_fail
`endif
    );

    modport slave (
        input  i_start,
        input  i_expected,
        output o_busy,
        output o_done,
        output o_table,
        output o_match
`ifdef TT_SWEEP_FAIL_INFO_EN
        ,
        output o_fail_valid,
        output o_first_fail
`endif
    );

endinterface

// File: rtl/tt_settle_counter.sv
// Loadable down-counter; terminal count flags the last settle cycle of a combination.
module tt_settle_counter #(
    parameter int unsigned MAX_COUNT = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_tc_c
);

    localparam int unsigned CNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MAX_COUNT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign o_tc_c = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = LOAD_VAL;
        end else if (i_dec && !o_tc_c) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 8 input combinations of a 3-input unit, captures its truth table and checks it.
// Define TT_SWEEP_FAIL_INFO_EN to report the index of the first mismatching combination.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_y,
    output logic o_a,
    output logic o_b,
    output logic o_c,
    truth_table_sweeper_if.slave ctl
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TT_WIDTH-1:0] exp_q, exp_d;
    logic [TT_WIDTH-1:0] table_q, table_d;
    logic [IDX_W-1:0]    stim_q, stim_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                match_q, match_d;
    logic                fail_valid_q, fail_valid_d;
    logic [IDX_W-1:0]    first_fail_q, first_fail_d;
    logic                cnt_load_c;
    logic                cnt_dec_c;
    logic                settle_tc_c;

    tt_settle_counter #(
        .MAX_COUNT (SETTLE_CYCLES)
    ) u_settle (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (cnt_load_c),
        .i_dec  (cnt_dec_c),
        .o_tc_c (settle_tc_c)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        exp_d        = exp_q;
        table_d      = table_q;
        match_d      = match_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;
        cnt_load_c   = 1'b0;
        cnt_dec_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctl.i_start) begin
                    exp_d        = ctl.i_expected;
                    table_d      = '0;
                    match_d      = 1'b0;
                    idx_d        = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                    cnt_load_c   = 1'b1;
                    state_d      = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                cnt_dec_c = 1'b1;
                if (settle_tc_c) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                table_d[idx_q] = i_y;
                if (i_y != exp_q[idx_q] && !fail_valid_q) begin
                    fail_valid_d = 1'b1;
                    first_fail_d = idx_q;
                end
                // Compare against the table including this last sample.
                if (idx_q == IDX_LAST) begin
                    match_d = (table_d == exp_q);
                    state_d = ST_DONE;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    cnt_load_c = 1'b1;
                    state_d    = ST_DRIVE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        stim_d = (state_d == ST_DRIVE || state_d == ST_SAMPLE) ? idx_d : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            exp_q        <= '0;
            table_q      <= '0;
            stim_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            match_q      <= 1'b0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            exp_q        <= exp_d;
            table_q      <= table_d;
            stim_q       <= stim_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            match_q      <= match_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign o_a         = stim_q[2];
    assign o_b         = stim_q[1];
    assign o_c         = stim_q[0];
    assign ctl.o_busy  = busy_q;
    assign ctl.o_done  = done_q;
    assign ctl.o_table = table_q;
    assign ctl.o_match = match_q;

`ifdef TT_SWEEP_FAIL_INFO_EN
    assign ctl.o_fail_valid = fail_valid_q;
    assign ctl.o_first_fail = first_fail_q;
`endif

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer and collector for the 3-input combinational unit under test (ports i_a/i_b/i_c → o_y). On a start request it drives all eight input combinations in ascending order, waits a programmable settle time for each, samples the unit's output and assembles an 8-bit truth table. At the end it compares the table with an expected value and reports pass/fail. It sits directly upstream (drives a, b, c) and downstream (consumes y) of the combinational stage, and replaces hand-written stimulus sweeps in hardware.

## Interface
Parameters:
- SETTLE_CYCLES, 2, cycles each combination is held before y is sampled; legal range 1..255

Ports:
- i_clk  in  1  single system clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start request; accepted only in IDLE
- i_expected  in  8  expected truth table; bit k = y for {a,b,c} = k
- i_y  in  1  output of the unit under test
- o_a  out  1  stimulus a (index bit 2)
- o_b  out  1  stimulus b (index bit 1)
- o_c  out  1  stimulus c (index bit 0)
- o_busy  out  1  high from first DRIVE cycle until the DONE cycle inclusive
- o_done  out  1  one-cycle pulse when the sweep finishes
- o_table  out  8  captured truth table
- o_match  out  1  o_table == captured expected, valid from o_done onward

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: i_start=1 → capture i_expected into exp register, clear o_table, clear index, load settle counter, → DRIVE.
- DRIVE: {o_a,o_b,o_c} = index; settle counter decrements each cycle; after SETTLE_CYCLES cycles in DRIVE → SAMPLE.
- SAMPLE: o_table[index] <= i_y; stimulus still held. index==7 → DONE; else index+1, reload settle counter, → DRIVE.
- DONE: o_done=1 for one cycle; o_match <= (o_table == exp); → IDLE.
- In IDLE, {o_a,o_b,o_c} = 3'b000; o_table and o_match hold last result until the next accepted start.
- i_start outside IDLE (including the DONE cycle) is ignored; not queued.
- Index is 3 bits; never wraps, since SAMPLE at index 7 exits.
- Reset values: o_a=o_b=o_c=0, o_busy=0, o_done=0, o_table=8'h00, o_match=0, state IDLE, index 0.

## Timing
- Start sampled at edge 0 → DRIVE from cycle 1.
- Each combination occupies SETTLE_CYCLES+1 cycles (DRIVE × S, SAMPLE × 1).
- o_done high in cycle 8·(S+1)+1; for S=2 that is cycle 25.
- o_match and final o_table valid in the o_done cycle; o_match is registered in the same edge that enters DONE, from the complete table.
- i_y is sampled on the rising edge ending the SAMPLE cycle, at least S+1 cycles after the stimulus changed.
- Reset mid-sweep: next edge returns every register to its reset value; no o_done pulse.
- Reset and start asserted together: reset wins.

## Configuration
- TT_SWEEP_FAIL_INFO_EN defined: extra outputs o_fail_valid (1 bit) and o_first_fail (3 bits). At each SAMPLE, if i_y != exp[index] and o_fail_valid=0, then o_first_fail <= index and o_fail_valid <= 1. Both cleared on accepted start and on reset (reset values 0).
- Not defined: ports and logic absent; only o_match reports the result.

## Structure
- Shared package tt_sweep_pkg: state encoding (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3), TT_WIDTH=8, IDX_W=3.
- One sub-module: tt_settle_counter (loadable down-counter with terminal-count flag, width sized from SETTLE_CYCLES).
- FSM, index register, table register and comparison stay in the top.

## Test plan
- i_y driven by the model y = (a&b)|c, i_expected=8'hEA, S=2, start pulse → o_table=8'hEA, o_match=1, o_done only in cycle 25, o_busy high for cycles 1–25.
- Same model, i_expected=8'hE8 → o_match=0; with TT_SWEEP_FAIL_INFO_EN: o_fail_valid=1, o_first_fail=3'd1.
- i_y tied 0, i_expected=8'h00, S=1 → o_table=8'h00, o_match=1, o_done in cycle 17; stimulus steps 000,001,…,111 every 2 cycles.
- i_start pulsed again at cycle 10 and in the DONE cycle → ignored: one o_done only, timing unchanged.
- i_rst asserted at cycle 12 mid-sweep → next cycle all outputs at reset values, no o_done; a new start gives a full correct sweep.
- i_expected changed during the sweep → no effect; the comparison uses the value captured at start.
